// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types and helpers for the AHB per-slave-port arbiter.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_BURST
  } arb_state_type;

  // Encodes a one-hot vector (up to 32 bits) to its bit index; zero input gives 0.
  function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
    logic [4:0] b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) b = b | i[4:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Request/grant bundle between the masters' decoders and one slave-port arbiter.
interface ahb_slave_arbiter_if #(
  parameter int unsigned SLAVE_X_MASTER_NUM = 4,
  parameter int unsigned MASTER_ID_WIDTH    = $clog2(SLAVE_X_MASTER_NUM)
);
  import ahb_slave_arbiter_pkg::*;

  logic [SLAVE_X_MASTER_NUM-1:0] hreq;
  htrans_type                    htrans [SLAVE_X_MASTER_NUM];
  logic                          hready;
  logic [SLAVE_X_MASTER_NUM-1:0] hgrant;
  logic [MASTER_ID_WIDTH-1:0]    addr_owner;
  logic [MASTER_ID_WIDTH-1:0]    data_owner;
  logic                          data_valid;

  // Fabric side: drives requests, consumes grants and ownership.
  modport master (
    output hreq, htrans, hready,
    input  hgrant, addr_owner, data_owner, data_valid
  );

  // Arbiter side.
  modport slave (
    input  hreq, htrans, hready,
    output hgrant, addr_owner, data_owner, data_valid
  );

endinterface

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational request picker: round-robin after i_ptr, or fixed
// priority (lowest index wins) when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb_rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  logic [W-1:0] w_idx;

`ifdef AHB_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Lowest-index requester wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = W'(i);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end
`else
  // First requester found scanning upward from i_ptr+1, wrapping.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = W'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave-port AHB arbiter: grants one master at a time, holds the grant
// across SEQ/BUSY bursts and tracks address/data-phase ownership.
// Optional macro AHB_ARB_FIXED_PRIO_EN: fixed priority picker, no pointer.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int unsigned SLAVE_X_MASTER_NUM = 4,
  parameter int unsigned MASTER_ID_WIDTH    = $clog2(SLAVE_X_MASTER_NUM)
) (
  input  logic               hclk,
  input  logic               hreset_n,
  ahb_slave_arbiter_if.slave bus
);

  arb_state_type                 r_state;
  logic [SLAVE_X_MASTER_NUM-1:0] r_hgrant;
  logic [MASTER_ID_WIDTH-1:0]    r_addr_owner;
  logic [MASTER_ID_WIDTH-1:0]    r_data_owner;
  logic                          r_data_valid;

  htrans_type                    w_own_trans;
  logic                          w_own_req;
  logic                          w_own_seqbusy;
  logic                          w_own_xfer;
  logic                          w_hold;
  logic [MASTER_ID_WIDTH-1:0]    w_pick_ptr;
  logic [SLAVE_X_MASTER_NUM-1:0] w_win;
  logic                          w_win_valid;
  logic [MASTER_ID_WIDTH-1:0]    w_win_id;

  assign w_own_trans   = bus.htrans[r_addr_owner];
  assign w_own_req     = bus.hreq[r_addr_owner];
  assign w_own_seqbusy = (w_own_trans == SEQ) || (w_own_trans == BUSY);
  assign w_own_xfer    = (w_own_trans == NONSEQ) || (w_own_trans == SEQ);

  // Entering a burst from GRANT only needs SEQ/BUSY; once in BURST the owner
  // must also keep hreq up, otherwise the burst is treated as terminated.
  assign w_hold = ((r_state == ARB_GRANT) && w_own_seqbusy) ||
                  ((r_state == ARB_BURST) && w_own_seqbusy && w_own_req);

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign w_pick_ptr = '0;
`else
  logic [MASTER_ID_WIDTH-1:0] r_ptr;
  // While an owner exists the search starts after it, so it ends up last.
  assign w_pick_ptr = (r_state == ARB_IDLE) ? r_ptr : r_addr_owner;
`endif

  ahb_rr_picker #(
    .N (SLAVE_X_MASTER_NUM),
    .W (MASTER_ID_WIDTH)
  ) u_picker (
    .i_req   (bus.hreq),
    .i_ptr   (w_pick_ptr),
    .o_grant (w_win),
    .o_valid (w_win_valid)
  );

  assign w_win_id = MASTER_ID_WIDTH'(onehot2bin(32'(w_win)));

  // Arbitration FSM and data-phase pipeline; everything freezes while hready=0.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state      <= ARB_IDLE;
      r_hgrant     <= '0;
      r_addr_owner <= '0;
      r_data_owner <= '0;
      r_data_valid <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      r_ptr        <= MASTER_ID_WIDTH'(SLAVE_X_MASTER_NUM - 1);
`endif
    end else if (bus.hready) begin
      r_data_valid <= (|r_hgrant) && w_own_xfer;
      r_data_owner <= r_addr_owner;
      case (r_state)
        ARB_IDLE: begin
          if (w_win_valid) begin
            r_hgrant     <= w_win;
            r_addr_owner <= w_win_id;
            r_state      <= ARB_GRANT;
          end
        end
        ARB_GRANT, ARB_BURST: begin
          if (w_hold) begin
            r_state <= ARB_BURST;
          end else begin
`ifndef AHB_ARB_FIXED_PRIO_EN
            r_ptr <= r_addr_owner;
`endif
            if (w_win_valid) begin
              r_hgrant     <= w_win;
              r_addr_owner <= w_win_id;
              r_state      <= ARB_GRANT;
            end else begin
              r_hgrant <= '0;
              r_state  <= ARB_IDLE;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.hgrant     = r_hgrant;
  assign bus.addr_owner = r_addr_owner;
  assign bus.data_owner = r_data_owner;
  assign bus.data_valid = r_data_valid;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Randomized self-checking bench for ahb_slave_arbiter with a behavioural model.
module tb_ahb_slave_arbiter;
  import ahb_slave_arbiter_pkg::*;

`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic hclk;
  logic hreset_n;

  ahb_slave_arbiter_if #(.SLAVE_X_MASTER_NUM(4)) bus ();

  ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(4)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: owner index (-1 = nobody), burst flag, rr pointer, pipeline.
  int m_owner, m_ptr, m_addr, m_downer;
  bit m_burst, m_dv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] req, input int ptr);
    if (RR) begin
      for (int k = 1; k <= 4; k++)
        if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end else begin
      for (int i = 0; i < 4; i++)
        if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 3; m_addr = 0; m_downer = 0; m_burst = 0; m_dv = 0;
  endtask

  task automatic model_update();
    logic [3:0] rq;
    htrans_type t;
    int w;
    bit keep;
    rq = bus.hreq;
    if (!bus.hready) return;
    if (m_owner >= 0) t = bus.htrans[m_owner];
    else t = IDLE;
    m_dv     = (m_owner >= 0) && (t == NONSEQ || t == SEQ);
    m_downer = m_addr;
    if (m_owner < 0) begin
      w = pick(rq, m_ptr);
      if (w >= 0) begin m_owner = w; m_addr = w; m_burst = 0; end
    end else begin
      keep = (t == SEQ || t == BUSY) && (!m_burst || rq[m_owner]);
      if (keep) m_burst = 1;
      else begin
        m_ptr = m_owner; m_burst = 0;
        w = pick(rq, m_owner);
        m_owner = w;
        if (w >= 0) m_addr = w;
      end
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    @(posedge hclk);
    model_update();
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("hgrant", 32'(bus.hgrant), 32'(eg));
    if (m_owner >= 0) chk("addr_owner", 32'(bus.addr_owner), 32'(m_addr));
    chk("data_owner", 32'(bus.data_owner), 32'(m_downer));
    chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
  endtask

  // tr packs per-master htrans: bits [2i+1:2i] belong to master i.
  task automatic set(input logic [3:0] rq, input logic [7:0] tr, input logic rdy);
    bus.hreq = rq;
    for (int i = 0; i < 4; i++) bus.htrans[i] = htrans_type'(tr[2*i +: 2]);
    bus.hready = rdy;
  endtask

  function automatic logic [7:0] tr4(input htrans_type t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic do_reset();
    hreset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_hgrant", 32'(bus.hgrant), 32'd0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_addr_owner", 32'(bus.addr_owner), 32'd0);
    chk("rst_data_owner", 32'(bus.data_owner), 32'd0);
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  initial begin
    hreset_n = 1'b1;
    set(4'b0000, 8'h00, 1'b1);
    #2;
    do_reset();

    // First grant and data phase.
    set(4'b0101, tr4(NONSEQ, NONSEQ, NONSEQ, NONSEQ), 1'b1);
    step();
    chk("t1_grant", 32'(bus.hgrant), 32'h1);
    chk("t1_addr", 32'(bus.addr_owner), 32'd0);
    step();
    chk("t1_dv", 32'(bus.data_valid), 32'd1);
    chk("t1_downer", 32'(bus.data_owner), 32'd0);

    // Back-to-back singles from all masters.
    do_reset();
    set(4'b1111, tr4(NONSEQ, NONSEQ, NONSEQ, NONSEQ), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rotate", 32'(bus.hgrant), RR ? 32'(1 << (i % 4)) : 32'h1);
    end

    // INCR4 on master 1 with master 2 waiting, hready stall mid-burst.
    do_reset();
    set(4'b0110, tr4(IDLE, NONSEQ, NONSEQ, IDLE), 1'b1);
    step(); chk("burst_b1", 32'(bus.hgrant), 32'h2);
    set(4'b0110, tr4(IDLE, SEQ, NONSEQ, IDLE), 1'b1);
    step(); chk("burst_b2", 32'(bus.hgrant), 32'h2);
    step(); chk("burst_b3", 32'(bus.hgrant), 32'h2);
    set(4'b0110, tr4(IDLE, SEQ, NONSEQ, IDLE), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_grant", 32'(bus.hgrant), 32'h2);
      chk("stall_dv", 32'(bus.data_valid), 32'd1);
    end
    set(4'b0110, tr4(IDLE, SEQ, NONSEQ, IDLE), 1'b1);
    step(); chk("burst_b4", 32'(bus.hgrant), 32'h2);
    set(4'b0100, tr4(IDLE, IDLE, NONSEQ, IDLE), 1'b1);
    step(); chk("burst_switch", 32'(bus.hgrant), 32'h4);
    set(4'b0100, tr4(IDLE, IDLE, SEQ, IDLE), 1'b1);
    step();
    // Reset in the middle of master 2's burst, then full contention.
    do_reset();
    set(4'b1111, tr4(NONSEQ, NONSEQ, NONSEQ, NONSEQ), 1'b1);
    step(); chk("post_rst_grant", 32'(bus.hgrant), 32'h1);

    // Master 3 abandons an undefined-length INCR during BUSY.
    do_reset();
    set(4'b1000, tr4(IDLE, IDLE, IDLE, NONSEQ), 1'b1);
    step(); chk("drop_g0", 32'(bus.hgrant), 32'h8);
    set(4'b1000, tr4(IDLE, IDLE, IDLE, SEQ), 1'b1);
    step();
    set(4'b1000, tr4(IDLE, IDLE, IDLE, BUSY), 1'b1);
    step(); chk("drop_busy", 32'(bus.hgrant), 32'h8);
    set(4'b0001, tr4(NONSEQ, IDLE, IDLE, BUSY), 1'b1);
    step(); chk("drop_next", 32'(bus.hgrant), 32'h1);
    set(4'b0000, tr4(IDLE, IDLE, IDLE, IDLE), 1'b1);
    step(); chk("drop_idle", 32'(bus.hgrant), 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      set(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
      step();
      if (c == 400) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
